// File: rtl/systolic_mac_array_pkg.sv
// Shared definitions for the output-stationary systolic MAC array:
// state encoding, array-dimension derivation and result slice indexing.
package systolic_mac_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  // Index of the last accumulate edge, counted from the first in_valid edge.
  function automatic int calc_final_cnt(input int max_dim);
    return 3 * max_dim - 3;
  endfunction

  function automatic int res_idx(input int i, input int j, input int max_dim);
    return i * max_dim + j;
  endfunction

endpackage

// File: rtl/systolic_mac_array_pe.sv
// One processing element: forwards A right and B down, accumulates a*b
// into a truncated accumulator and flags any unsigned overflow (sticky).
module systolic_pe
  import systolic_mac_array_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [DW-1:0] acc,
  output logic          ovf
);

  logic [DW-1:0]   a_q, b_q, acc_q;
  logic            ovf_q;
  logic [2*DW-1:0] prod;
  logic [DW:0]     sum;

  assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  assign sum  = {1'b0, acc_q} + {1'b0, prod[DW-1:0]};

  always_ff @(posedge clk) begin
    if (clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= sum[DW-1:0];
      if ((|prod[2*DW-1:DW]) || sum[DW]) ovf_q <= 1'b1;
    end else begin
      // Idle/done: flush the pass chain so nothing leaks into a later stream.
      a_q <= '0;
      b_q <= '0;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary MAX_DIM x MAX_DIM systolic MAC array with its sequencing
// FSM; the product stays in the accumulators until clear/reset.
module systolic_mac_array
  import systolic_mac_array_pkg::*;
#(
  parameter int data_width = 32,
  parameter int bus_width  = 64,
  localparam int MAX_DIM   = calc_max_dim(bus_width, data_width)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  in_valid,
  input  logic [MAX_DIM*data_width-1:0]         vectorA,
  input  logic [MAX_DIM*data_width-1:0]         vectorB,
  output logic [MAX_DIM*MAX_DIM*data_width-1:0] result,
  output logic                                  result_valid,
  output logic                                  busy,
  output logic                                  overflow
);

  localparam int FINAL_CNT = calc_final_cnt(MAX_DIM);
  localparam int CNT_W     = $clog2(3 * MAX_DIM);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             result_valid_q;
  logic             busy_q;
  logic             clr;
  logic             pe_en;

  assign clr   = reset | clear;
  assign pe_en = (state_q == ST_RUN) || ((state_q == ST_IDLE) && in_valid);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(FINAL_CNT)) begin
            state_q        <= ST_DONE;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign busy         = busy_q;

  logic [data_width-1:0]      a_out_w [MAX_DIM][MAX_DIM];
  logic [data_width-1:0]      b_out_w [MAX_DIM][MAX_DIM];
  logic [MAX_DIM*MAX_DIM-1:0] ovf_w;

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      logic [data_width-1:0] a_in_w, b_in_w, acc_w;

      if (gj == 0) begin : g_a_edge
        assign a_in_w = vectorA[gi*data_width +: data_width];
      end else begin : g_a_link
        assign a_in_w = a_out_w[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in_w = vectorB[gj*data_width +: data_width];
      end else begin : g_b_link
        assign b_in_w = b_out_w[gi-1][gj];
      end

      systolic_pe #(.DW(data_width)) u_pe (
        .clk   (clk),
        .clr   (clr),
        .en    (pe_en),
        .a_in  (a_in_w),
        .b_in  (b_in_w),
        .a_out (a_out_w[gi][gj]),
        .b_out (b_out_w[gi][gj]),
        .acc   (acc_w),
        .ovf   (ovf_w[res_idx(gi, gj, MAX_DIM)])
      );

      assign result[res_idx(gi, gj, MAX_DIM)*data_width +: data_width] = acc_w;
    end
  end

  assign overflow = |ovf_w;

endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- Output-stationary MAX_DIM x MAX_DIM systolic multiply-accumulate array.
- Sits directly downstream of the operand-A and operand-B zero-padding/skew stages.
- Consumes one skewed row-vector of A and one skewed column-vector of B per cycle.
- Produces C = A x B, held in place until the top-level done/clear pulse.

Parameters:
- data_width, 32, width of each matrix element and of each accumulator (results truncated to this width).
- bus_width, 64, APB data bus width. Local constant MAX_DIM = bus_width/data_width (default 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; returns the whole block to IDLE with all registers zero.
- clear  in  1  synchronous, active-high; top-level done pulse, identical in effect to reset.
- in_valid  in  1  high while the padding stages drive the skewed stream; both padding stages must be done.
- vectorA  in  MAX_DIM*data_width  element i = row i of A, skewed.
- vectorB  in  MAX_DIM*data_width  element j = column j of B, skewed.
- result  out  MAX_DIM*MAX_DIM*data_width  C(i,j) at slice index i*MAX_DIM+j.
- result_valid  out  1  high while result holds the final product.
- busy  out  1  high in RUN.
- overflow  out  1  sticky; set if any product or accumulation exceeded data_width bits (unsigned).

Behaviour:
- Reset/clear values: all outputs 0, all PE pipeline and accumulator registers 0, state IDLE. clear has priority over in_valid.
- Operands are unsigned.
- Stream contract: at feed step t = 0..2*MAX_DIM-2:
  - vectorA[i] = A(i, t-i), else 0.
  - vectorB[j] = B(t-j, j), else 0.
  - Inputs are zero outside the stream.
- PE(i,j), on each enabled edge:
  - a_in from PE(i,j-1) a_out, or vectorA[i] for j=0.
  - b_in from PE(i-1,j) b_out, or vectorB[j] for i=0.
  - a_out<=a_in; b_out<=b_in; acc<=acc+a_in*b_in, truncated to data_width.
- Product pairing: A(i,k)*B(k,j) meets in PE(i,j) at edge k+i+j, with edge 0 = first in_valid sample.
- State machine:
  - IDLE: PEs disabled (acc held, pass registers load 0), except on an edge with in_valid=1. That edge is enabled, and the block moves to RUN with cnt<=1.
  - RUN: PEs enabled every edge; in_valid ignored for control; cnt increments. The edge where cnt==3*MAX_DIM-3 is the last accumulate edge: go to DONE, result_valid<=1.
  - DONE: PEs disabled, pass registers zeroed, acc held; result_valid=1. in_valid ignored. Leaves only via clear/reset (to IDLE).
- Latency: result_valid rises after edge 3*MAX_DIM-3 (edge 3 for MAX_DIM=2, i.e. the 4th edge counting the first in_valid edge).
- cnt width: clog2(3*MAX_DIM) bits.
- overflow: set in any enabled PE when the full-width product's upper bits are nonzero or the truncated add carries out. Held until clear/reset.
- Boundary conditions:
  - reset/clear mid-RUN aborts immediately; partial sums are discarded.
  - in_valid dropping mid-RUN does not stall; zeros propagate.
  - in_valid held high in DONE has no effect.
  - A new stream starting on the same edge clear deasserts is accepted on the following edge.

Decomposition:
- Shared package holds:
  - MAX_DIM derivation.
  - State encoding (IDLE=0, RUN=1, DONE=2).
  - FINAL_CNT = 3*MAX_DIM-3.
  - Flattened result slice-index function (i*MAX_DIM+j).
- One sub-module: systolic_pe (a/b pass registers, accumulator, overflow flag, enable, clear).
- Top level generates the MAX_DIM^2 PE grid and the control FSM.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]]: stream vectorA {1,0},{2,3},{0,4}; vectorB {5,0},{7,6},{0,8}.
  -> result_valid after edge 3; C=[[19,22],[43,50]]; overflow=0; busy low afterward.
- Same stream, then clear, then A=I, B=[[9,10],[11,12]].
  -> C=[[9,10],[11,12]]; no residue from the first run.
- reset asserted at edge 2 of a run.
  -> result=0, result_valid=0, busy=0 next cycle; a subsequent full stream gives the correct C.
- A(0,0)=B(0,0)=0x10000, other elements 0.
  -> C(0,0)=0 (truncated), overflow=1, which holds until clear.
- in_valid held high continuously after DONE, with nonzero garbage on the vectors.
  -> result unchanged, result_valid stays 1.
- clear and in_valid asserted together.
  -> state IDLE, all zero; the stream is accepted from the next in_valid edge.
